// File: rtl/vga_pkg.sv
// Shared constants and stage bundle for the
// sprite compositor pixel pipeline.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic SHAPE_BOX   = 1'b0;
  localparam logic SHAPE_CROSS = 1'b1;

  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_BLUE  = 3'b001;
  localparam logic [2:0] RGB_BLACK = 3'b000;

  typedef struct packed {
    logic da;
    logic hs;
    logic vs;
    logic bl;
    logic border;
  } s1_s2_t;

endpackage

// File: rtl/sprite_hit.sv
// Combinational box/cross coverage test of one
// sprite against the current pixel.
module sprite_hit
  import vga_pkg::*;
#(
  parameter int SPR_W = 10,
  parameter int SPR_H = 10,
  parameter int X_W   = 10,
  parameter int Y_W   = 9
) (
  input  logic [9:0]     xCount,
  input  logic [9:0]     yCount,
  input  logic [X_W-1:0] sx,
  input  logic [Y_W-1:0] sy,
  input  logic           shape,
  output logic           hit
);

  localparam int MW = (X_W > Y_W) ? X_W : Y_W;
  localparam int CW = ((MW > 10) ? MW : 10) + 3;

  localparam logic signed [CW-1:0] W  = CW'(SPR_W);
  localparam logic signed [CW-1:0] H  = CW'(SPR_H);
  localparam logic signed [CW-1:0] W2 = CW'(2 * SPR_W);
  localparam logic signed [CW-1:0] H2 = CW'(2 * SPR_H);

  logic signed [CW-1:0] px, py, x0, y0;
  logic signed [CW-1:0] lo, loC;
  logic rows, cols, box;
  logic left, right, lower;

  assign px = $signed(CW'(xCount));
  assign py = $signed(CW'(yCount));
  assign x0 = $signed(CW'(sx));
  assign y0 = $signed(CW'(sy));

  // left arm clips at column 0 instead of wrapping
  assign lo  = x0 - W;
  assign loC = lo[CW-1] ? '0 : lo;

  assign rows = (py > y0) && (py < y0 + H);
  assign cols = (px > x0) && (px < x0 + W);
  assign box  = rows && cols;

  assign left  = rows && (px > loC) && (px < x0);
  assign right = rows && (px > x0 + W) && (px < x0 + W2);
  assign lower = cols && (py > y0 + H) && (py < y0 + H2);

  assign hit = box ||
    ((shape == SHAPE_CROSS) && (left || right || lower));

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite/border/overlay compositor with
// per-frame shadow latch and collision flags.
module sprite_compositor
  import vga_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W       = 10,
  parameter int SPR_H       = 10,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int BORDER      = 11
) (
  input  logic                       VGA_clk,
  input  logic                       resetn,
  input  logic [9:0]                 xCount,
  input  logic [9:0]                 yCount,
  input  logic                       displayArea,
  input  logic                       hSync_in,
  input  logic                       vSync_in,
  input  logic                       blank_n_in,
  input  logic [NUM_SPRITES*X_W-1:0] spr_x,
  input  logic [NUM_SPRITES*Y_W-1:0] spr_y,
  input  logic [NUM_SPRITES-1:0]     spr_en,
  input  logic [NUM_SPRITES-1:0]     spr_shape,
  input  logic [NUM_SPRITES*3-1:0]   spr_rgb,
  input  logic                       win,
  input  logic                       lose,
  output logic [7:0]                 VGA_R,
  output logic [7:0]                 VGA_G,
  output logic [7:0]                 VGA_B,
  output logic                       VGA_hSync,
  output logic                       VGA_vSync,
  output logic                       blank_n,
  output logic                       frame_done,
  output logic [NUM_SPRITES-1:0]     coll_flags
);

  localparam int N = NUM_SPRITES;

  logic [N*X_W-1:0] shX;
  logic [N*Y_W-1:0] shY;
  logic [N-1:0]     shEn;
  logic [N-1:0]     shShape;
  logic [N*3-1:0]   shRgb;
  logic [N-1:0]     collAcc;

  logic [N-1:0] rawHit, hit0, hit1;
  logic         latch, border0, multi;
  s1_s2_t       s1;
  logic [2:0]   sprRgb, rgbNext, rgb2;
  logic         sprAny;

  assign latch = (xCount == 10'd0) &&
                 (yCount == 10'(V_ACTIVE));

  for (genvar i = 0; i < N; i++) begin : g_spr
    sprite_hit #(
      .SPR_W(SPR_W),
      .SPR_H(SPR_H),
      .X_W  (X_W),
      .Y_W  (Y_W)
    ) u_hit (
      .xCount(xCount),
      .yCount(yCount),
      .sx    (shX[i*X_W +: X_W]),
      .sy    (shY[i*Y_W +: Y_W]),
      .shape (shShape[i]),
      .hit   (rawHit[i])
    );
  end

  assign hit0 = rawHit & shEn & {N{displayArea}};

  assign border0 = (BORDER != 0) && (
    (xCount <  10'(BORDER)) ||
    (xCount >= 10'(H_ACTIVE - BORDER)) ||
    (yCount <  10'(BORDER)) ||
    (yCount >= 10'(V_ACTIVE - BORDER)));

  // two or more hits on the same pixel
  assign multi = |(hit1 & (hit1 - N'(1)));

  always_ff @(posedge VGA_clk or negedge resetn) begin
    if (!resetn) begin
      shX        <= '0;
      shY        <= '0;
      shEn       <= '0;
      shShape    <= '0;
      shRgb      <= '0;
      collAcc    <= '0;
      coll_flags <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= latch;
      if (latch) begin
        shX        <= spr_x;
        shY        <= spr_y;
        shEn       <= spr_en;
        shShape    <= spr_shape;
        shRgb      <= spr_rgb;
        coll_flags <= collAcc;
        collAcc    <= '0;
      end else if (multi) begin
        collAcc <= collAcc | hit1;
      end
    end
  end

  always_ff @(posedge VGA_clk or negedge resetn) begin
    if (!resetn) begin
      hit1 <= '0;
      s1   <= '{da: 1'b0, hs: 1'b1, vs: 1'b1,
                bl: 1'b0, border: 1'b0};
    end else begin
      hit1 <= hit0;
      s1   <= '{da: displayArea, hs: hSync_in,
                vs: vSync_in, bl: blank_n_in,
                border: border0};
    end
  end

  always_comb begin
    sprAny = 1'b0;
    sprRgb = RGB_BLACK;
    for (int i = 0; i < N; i++) begin
      if (hit1[i] && !sprAny) begin
        sprAny = 1'b1;
        sprRgb = shRgb[i*3 +: 3];
      end
    end
    priority case (1'b1)
      !s1.da:    rgbNext = RGB_BLACK;
      lose:      rgbNext = RGB_RED;
      win:       rgbNext = RGB_GREEN;
      sprAny:    rgbNext = sprRgb;
      s1.border: rgbNext = RGB_BLUE;
      default:   rgbNext = RGB_BLACK;
    endcase
  end

  always_ff @(posedge VGA_clk or negedge resetn) begin
    if (!resetn) begin
      rgb2      <= RGB_BLACK;
      VGA_hSync <= 1'b1;
      VGA_vSync <= 1'b1;
      blank_n   <= 1'b0;
    end else begin
      rgb2      <= rgbNext;
      VGA_hSync <= s1.hs;
      VGA_vSync <= s1.vs;
      blank_n   <= s1.bl;
    end
  end

  assign VGA_R = {8{rgb2[2]}};
  assign VGA_G = {8{rgb2[1]}};
  assign VGA_B = {8{rgb2[0]}};

endmodule
